// File: rtl/kypd_pkg.sv
// kypd_pkg -- shared definitions for the 4x4 matrix keypad scanner.
//   KEY_MAP     : hex code for each key, indexed by frame bit 4*col + row
//   kp_state_e  : key-reporting FSM states
//   hot_info_t  : result of onehot_info() (single-key check + key index)
package kypd_pkg;

  // Pmod KYPD legend. Column 0 carries 1/4/7/0 and column 3 carries A/B/C/D.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    BLOCKED = 2'd2
  } kp_state_e;

  typedef struct packed {
    logic       one_hot;  // exactly one key down
    logic       any;      // at least one key down
    logic [3:0] idx;      // index of the highest set bit (the key when one_hot)
  } hot_info_t;

  function automatic hot_info_t onehot_info(input logic [15:0] f);
    hot_info_t r;
    int        n;
    r = '0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (f[i]) begin
        n     = n + 1;
        r.idx = 4'(i);
      end
    end
    r.one_hot = (n == 1);
    r.any     = (n != 0);
    return r;
  endfunction

endpackage

// File: rtl/kypd_scan_if.sv
// kypd_scan_if -- keypad pins plus the key report towards the setpoint logic.
//   kp_col    : column drive, active-low, one column low at a time
//   kp_row    : row sense, active-low, pulled up off-chip, asynchronous
//   key_code  : hex code of the last accepted key
//   key_valid : one-cycle strobe when a new key is accepted
//   key_held  : accepted key still debounced-pressed
// master = scanner side, slave = keypad/consumer side.
interface kypd_scan_if;
  logic [3:0] kp_col;
  logic [3:0] kp_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output kp_col,
    output key_code,
    output key_valid,
    output key_held,
    input  kp_row
  );

  modport slave (
    input  kp_col,
    input  key_code,
    input  key_valid,
    input  key_held,
    output kp_row
  );
endinterface

// File: rtl/scan_tick.sv
// scan_tick -- free-running divider producing a one-cycle enable every DIV
// clocks. Also usable as the refresh enable of the 7-segment driver.
//   clk  : system clock
//   rst  : synchronous, active-low reset (counter back to 0)
//   tick : high during the cycle in which the counter equals DIV-1
module scan_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 4) begin : g_div_check
    $error("scan_tick: DIV must be at least 4");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/kypd_scan.sv
// kypd_scan -- 4x4 matrix keypad scanner with frame-level debounce.
// Drives one column low per DIV-cycle dwell, reads the rows back through a
// 2-FF synchronizer, assembles a 16-bit pressed-key frame every four columns
// and accepts a frame once DEBOUNCE_SCANS consecutive frames agree. A small
// FSM turns accepted frames into single-key reports.
//   clk : system clock        rst : synchronous, active-low reset
//   kp  : kypd_scan_if.master (kp_col, kp_row, key_code, key_valid, key_held)
module kypd_scan
  import kypd_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic         clk,
  input  logic         rst,
  kypd_scan_if.master  kp
);

  localparam int         DIV   = CLK_FREQ_HZ / SCAN_HZ;
  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

  if (DIV < 4) begin : g_div_check
    $error("kypd_scan: CLK_FREQ_HZ/SCAN_HZ must be at least 4");
  end
  if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15) begin : g_deb_check
    $error("kypd_scan: DEBOUNCE_SCANS must be in 2..15");
  end

  logic tick;

  scan_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // ---- stage p0: row synchronizer ----
  logic [3:0] row_s1_p0;
  logic [3:0] row_s2_p0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_s1_p0 <= '0;
      row_s2_p0 <= '0;
    end else begin
      row_s1_p0 <= kp.kp_row;
      row_s2_p0 <= row_s1_p0;
    end
  end

  // ---- stage p1: column scan, frame assembly and debounce ----
  logic [1:0]  col_idx;
  logic [15:0] frame_p1;
  logic [15:0] last_frame_p1;
  logic [3:0]  stable_cnt_p1;
  logic [15:0] new_frame;
  logic        frame_done;

  // Row sample lands in the nibble of the column currently driven. The tick
  // sits at the end of the dwell, so the synchronizer has long settled.
  always_comb begin
    new_frame = frame_p1;
    new_frame[{col_idx, 2'b00} +: 4] = ~row_s2_p0;
  end

  assign frame_done = tick && (col_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_idx       <= '0;
      frame_p1      <= '0;
      last_frame_p1 <= '0;
      stable_cnt_p1 <= '0;
    end else begin
      if (tick) begin
        col_idx  <= col_idx + 2'd1;
        frame_p1 <= new_frame;
      end
      if (frame_done) begin
        if (new_frame == last_frame_p1) begin
          if (stable_cnt_p1 != DEB_N) begin
            stable_cnt_p1 <= stable_cnt_p1 + 4'd1;
          end
        end else begin
          stable_cnt_p1 <= 4'd1;
          last_frame_p1 <= new_frame;
        end
      end
    end
  end

  assign kp.kp_col = ~(4'b0001 << col_idx);

  // ---- stage p2: debounced frame ----
  // Reloading every cycle while the count is saturated is harmless:
  // last_frame only moves when the count drops back to 1.
  logic [15:0] deb_frame_p2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      deb_frame_p2 <= '0;
    end else if (stable_cnt_p1 == DEB_N) begin
      deb_frame_p2 <= last_frame_p1;
    end
  end

  // ---- stage p3: key reporting FSM ----
  kp_state_e  state;
  kp_state_e  state_nx;
  logic [3:0] key_bit;
  logic [3:0] key_bit_nx;
  logic [3:0] key_code_p3;
  logic [3:0] key_code_nx;
  logic       key_valid_p3;
  logic       key_valid_nx;
  logic       key_held_p3;
  logic       key_held_nx;
  hot_info_t  info;

  always_comb begin
    info         = onehot_info(deb_frame_p2);
    state_nx     = state;
    key_bit_nx   = key_bit;
    key_code_nx  = key_code_p3;
    key_valid_nx = 1'b0;
    key_held_nx  = key_held_p3;
    unique case (state)
      IDLE: begin
        if (info.one_hot) begin
          key_bit_nx   = info.idx;
          key_code_nx  = KEY_MAP[info.idx];
          key_valid_nx = 1'b1;
          key_held_nx  = 1'b1;
          state_nx     = PRESSED;
        end else if (info.any) begin
          state_nx = BLOCKED;
        end
      end
      PRESSED: begin
        // Anything other than the accepted key alone ends the report; a
        // chord or swap must be fully released before another key counts.
        if (!info.any) begin
          key_held_nx = 1'b0;
          state_nx    = IDLE;
        end else if (deb_frame_p2 != (16'h0001 << key_bit)) begin
          key_held_nx = 1'b0;
          state_nx    = BLOCKED;
        end
      end
      BLOCKED: begin
        if (!info.any) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx    = IDLE;
        key_held_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      key_bit      <= '0;
      key_code_p3  <= '0;
      key_valid_p3 <= 1'b0;
      key_held_p3  <= 1'b0;
    end else begin
      state        <= state_nx;
      key_bit      <= key_bit_nx;
      key_code_p3  <= key_code_nx;
      key_valid_p3 <= key_valid_nx;
      key_held_p3  <= key_held_nx;
    end
  end

  assign kp.key_code  = key_code_p3;
  assign kp.key_valid = key_valid_p3;
  assign kp.key_held  = key_held_p3;

endmodule

// File: tb/tb_kypd_scan.sv
// tb_kypd_scan -- bench for kypd_scan with a keypad matrix model, an
// event-level reference model and directed plus random key scenarios.
`timescale 1ns/1ps
module tb_kypd_scan;

  localparam int DIV = 10;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] keys = '0;   // bit 4*col + row = key held down

  kypd_scan_if kif ();

  kypd_scan #(
    .CLK_FREQ_HZ    (1000),
    .SCAN_HZ        (100),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif.master)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column when low.
  always_comb begin
    kif.kp_row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!kif.kp_col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[4*c + r]) kif.kp_row[r] = 1'b0;
        end
      end
    end
  end

  // ---------------- scoring ----------------
  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests = tests + 1;
    if (act !== req) begin
      fails = fails + 1;
      if (fails <= 30) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Frames are rebuilt from the key matrix itself: column c is sampled at
  // the last cycle of its dwell, seeing the keys from two cycles earlier.
  // Once DEB identical frames are seen, the key decision takes effect two
  // edges after the completing tick.
  logic [3:0] map_tb [16] = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                              4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};

  typedef struct packed {
    logic [31:0] due;
    logic [15:0] f;
  } ev_t;

  ev_t         evq [$];
  int          eidx  = 0;
  int          m     = 0;
  logic [15:0] h0 = '0, h1 = '0, h2 = '0;
  logic [15:0] mf = '0, mlast = '0;
  int          scnt  = 0;
  int          mstate = 0;   // 0 waiting, 1 one key reported, 2 locked out
  int          mkey  = 0;
  logic [3:0]  e_code  = 4'h0;
  logic        e_valid = 1'b0;
  logic        e_held  = 1'b0;
  logic [3:0]  e_col   = 4'b1110;

  function automatic void apply(input logic [15:0] f);
    int n;
    int idx;
    n = $countones(f);
    idx = 0;
    for (int i = 0; i < 16; i++) if (f[i]) idx = i;
    case (mstate)
      0: begin
        if (n == 1) begin
          e_code = map_tb[idx]; e_valid = 1'b1; e_held = 1'b1; mkey = idx; mstate = 1;
        end else if (n > 1) begin
          mstate = 2;
        end
      end
      1: begin
        if (n == 0) begin
          e_held = 1'b0; mstate = 0;
        end else if (!(n == 1 && idx == mkey)) begin
          e_held = 1'b0; mstate = 2;
        end
      end
      default: if (n == 0) mstate = 0;
    endcase
  endfunction

  always @(posedge clk) begin
    ev_t ev;
    int  c;
    eidx = eidx + 1;
    h2 = h1; h1 = h0; h0 = keys;
    e_valid = 1'b0;
    if (!rst) begin
      m = 0; mf = '0; mlast = '0; scnt = 0; evq.delete();
      mstate = 0; e_code = 4'h0; e_held = 1'b0;
    end else begin
      while (evq.size() > 0 && evq[0].due == 32'(eidx)) begin
        ev = evq.pop_front();
        apply(ev.f);
      end
      if (m % DIV == DIV - 1) begin
        c = (m / DIV) % 4;
        mf[4*c +: 4] = h2[4*c +: 4];
        if (c == 3) begin
          if (mf == mlast) begin
            if (scnt < DEB) scnt = scnt + 1;
          end else begin
            scnt = 1; mlast = mf;
          end
          if (scnt == DEB) evq.push_back('{due: 32'(eidx + 2), f: mlast});
        end
      end
      m = m + 1;
    end
    e_col = ~(4'b0001 << ((m / DIV) % 4));
  end

  // ---------------- per-cycle compare + pulse monitor ----------------
  int         nidx = 0;
  int         last_wrap = -100;
  int         vcnt = 0;
  logic [3:0] prev_col = 4'b1110;

  always @(negedge clk) begin
    nidx = nidx + 1;
    if (prev_col == 4'b0111 && kif.kp_col == 4'b1110) last_wrap = nidx;
    prev_col = kif.kp_col;
    chk("kp_col",    32'(kif.kp_col),    32'(e_col));
    chk("key_code",  32'(kif.key_code),  32'(e_code));
    chk("key_valid", 32'(kif.key_valid), 32'(e_valid));
    chk("key_held",  32'(kif.key_held),  32'(e_held));
    if (kif.key_valid === 1'b1) begin
      vcnt = vcnt + 1;
      chk("valid_latency", 32'(nidx - last_wrap), 32'd2);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, limit 900000 ns");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int          v0;
    int          r0;
    int          vseen;
    bit          found;
    int          kind;
    logic [3:0]  col_tbl [5];
    col_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset with random keys, then column walk.
    rst = 1'b0; keys = 16'($urandom);
    step(5);
    keys = '0; rst = 1'b1;
    chk("rst_kp_col",    32'(kif.kp_col),    32'h0000_000E);
    chk("rst_key_code",  32'(kif.key_code),  32'h0);
    chk("rst_key_valid", 32'(kif.key_valid), 32'h0);
    chk("rst_key_held",  32'(kif.key_held),  32'h0);
    for (int s = 0; s < 5; s++) begin
      for (int j = 0; j < 10; j++) begin
        chk("col_walk", 32'(kif.kp_col), 32'(col_tbl[s]));
        step(1);
      end
    end

    // Clean press of "5" (col1,row1).
    v0 = vcnt;
    keys = 16'h1 << 5;
    step(300);
    chk("p5_pulses", 32'(vcnt - v0), 32'd1);
    chk("p5_code",   32'(kif.key_code), 32'h5);
    chk("p5_held",   32'(kif.key_held), 32'h1);
    chk("model_code5", 32'(e_code), 32'h5);
    keys = '0;
    step(250);
    chk("p5_release_held",   32'(kif.key_held), 32'h0);
    chk("p5_release_pulses", 32'(vcnt - v0), 32'd1);
    chk("p5_code_kept",      32'(kif.key_code), 32'h5);

    // Bouncing "A" (col3,row0), then a steady hold.
    v0 = vcnt;
    for (int i = 0; i < 8; i++) begin
      keys = keys ^ (16'h1 << 12);
      step(25);
    end
    chk("bounce_pulses", 32'(vcnt - v0), 32'd0);
    keys = 16'h1 << 12;
    step(250);
    chk("bounce_hold_pulses", 32'(vcnt - v0), 32'd1);
    chk("bounce_code", 32'(kif.key_code), 32'hA);
    keys = '0;
    step(250);

    // Chord "1"+"D", partial release, full release, then "0".
    v0 = vcnt;
    keys = (16'h1 << 0) | (16'h1 << 15);
    step(250);
    chk("chord_pulses", 32'(vcnt - v0), 32'd0);
    chk("chord_held",   32'(kif.key_held), 32'h0);
    keys = 16'h1 << 0;
    step(250);
    chk("chord_partial_pulses", 32'(vcnt - v0), 32'd0);
    keys = '0;
    step(250);
    keys = 16'h1 << 3;
    step(250);
    chk("zero_pulses", 32'(vcnt - v0), 32'd1);
    chk("zero_code",   32'(kif.key_code), 32'h0);
    chk("model_code0", 32'(e_code), 32'h0);
    keys = '0;
    step(250);

    // Hold "3", add "9", release, press "3" again.
    v0 = vcnt;
    keys = 16'h1 << 8;
    step(250);
    chk("k3_pulses", 32'(vcnt - v0), 32'd1);
    chk("k3_code",   32'(kif.key_code), 32'h3);
    chk("k3_held",   32'(kif.key_held), 32'h1);
    keys = keys | (16'h1 << 10);
    step(250);
    chk("k3_add9_pulses", 32'(vcnt - v0), 32'd1);
    chk("k3_add9_held",   32'(kif.key_held), 32'h0);
    keys = '0;
    step(250);
    keys = 16'h1 << 8;
    step(250);
    chk("k3_again_pulses", 32'(vcnt - v0), 32'd2);
    chk("k3_again_code",   32'(kif.key_code), 32'h3);
    keys = '0;
    step(250);

    // Reset in the middle of holding "F" (col1,row3).
    keys = 16'h1 << 7;
    step(80);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    r0 = nidx;
    v0 = vcnt;
    chk("midrst_code_cleared", 32'(kif.key_code), 32'h0);
    found = 1'b0;
    vseen = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1);
      if (kif.key_valid === 1'b1) begin
        found = 1'b1;
        vseen = nidx;
      end
    end
    chk("midrst_found",   32'(found), 32'h1);
    chk("midrst_latency", 32'(vseen - r0), 32'd162);
    chk("midrst_pulses",  32'(vcnt - v0), 32'd1);
    chk("midrst_code",    32'(kif.key_code), 32'hF);
    keys = '0;
    step(250);

    // Random keys, chords and occasional resets against the model.
    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        rst = 1'b0;
        step(int'($urandom_range(1, 3)));
        rst = 1'b1;
      end else if (kind <= 3) begin
        keys = '0;
      end else if (kind <= 7) begin
        keys = 16'h1 << $urandom_range(0, 15);
      end else begin
        keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      end
      step(int'($urandom_range(30, 260)));
    end
    keys = '0;
    step(250);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
